// File: rtl/main_mem_arbiter_pkg.sv
// Shared sizing constants for the main memory arbiter and its users.
// Requester count is the agents plus codemaker and control tower.
package main_mem_arbiter_pkg;
    localparam int MAIN_MEMORY_ADDR_BITS = 6;
    localparam int NUMBER_OF_AGENTS      = 1;
endpackage

// File: rtl/main_mem_rr_pick.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
// Iterates farthest-to-nearest so the nearest asserted request is the last write.
module main_mem_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter for the single-port main memory with grant hold and
// bounded-tenure preemption; one access per cycle, ack one cycle after access.
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUMBER_OF_AGENTS + 2,
    parameter int ADDR_W   = MAIN_MEMORY_ADDR_BITS,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_in,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rd_data,
    output logic                  busy,
    output logic                  main_mem_we,
    output logic [ADDR_W-1:0]     main_mem_addr,
    output logic [31:0]           main_mem_in,
    input  logic [31:0]           main_mem_out
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state;
    logic [OW-1:0]      owner;
    logic [OW-1:0]      ptr;
    logic [OW-1:0]      pick_ptr;
    logic [OW-1:0]      winner;
    logic               any_req;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_REQ-1:0] owner_oh;
    logic               access;
    logic               contender;
    logic               hand_off;

    assign busy      = (state == ST_OWNED);
    assign owner_oh  = NUM_REQ'(1) << owner;
    assign access    = busy && req[owner];
    assign contender = |(req & ~owner_oh);
    // Preemption after MAX_HOLD accesses only when someone else is waiting;
    // >= keeps it armed once the counter has saturated with no contender.
    assign hand_off  = busy && (!req[owner] || (hold_cnt >= HW'(MAX_HOLD - 1) && contender));

    // While owned, the search starts after the current owner so a handover
    // never re-selects it; in IDLE it starts after the last owner.
    assign pick_ptr = busy ? owner : ptr;

    main_mem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign main_mem_we   = access && req_we[owner];
    assign main_mem_addr = access ? req_addr[owner*ADDR_W +: ADDR_W] : '0;
    assign main_mem_in   = access ? req_in[owner*32 +: 32] : '0;
    assign rd_data       = main_mem_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= OW'(NUM_REQ - 1);
            hold_cnt <= '0;
            grant    <= '0;
            ack      <= '0;
        end else begin
            ack <= access ? owner_oh : '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_OWNED;
                        owner    <= winner;
                        grant    <= NUM_REQ'(1) << winner;
                        hold_cnt <= '0;
                    end
                end
                ST_OWNED: begin
                    if (hand_off) begin
                        ptr      <= owner;
                        hold_cnt <= '0;
                        if (any_req) begin
                            owner <= winner;
                            grant <= NUM_REQ'(1) << winner;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
